// File: rtl/mac_dot_sequencer_if.sv
// Bus bundle for mac_dot_sequencer: configuration, operand stream, MAC
// control/operands and the result port. The master modport is the
// sequencer's view. The slave modport is the view of the surrounding
// environment (operand source, MAC unit, result consumer).
interface mac_dot_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int LEN_WIDTH  = 8
);
  logic [LEN_WIDTH-1:0]  cfg_len;
  logic                  cfg_go;
  logic                  busy;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_a;
  logic [DATA_WIDTH-1:0] s_b;
  logic                  mac_start;
  logic                  mac_clr_acc;
  logic [DATA_WIDTH-1:0] mac_a;
  logic [DATA_WIDTH-1:0] mac_b;
  logic                  mac_ready;
  logic [ACC_WIDTH-1:0]  mac_acc;
  logic                  res_valid;
  logic                  res_ready;
  logic [ACC_WIDTH-1:0]  res_data;
  logic [LEN_WIDTH-1:0]  res_count;

  modport master (
    input  cfg_len, cfg_go, s_valid, s_a, s_b, mac_ready, mac_acc, res_ready,
    output busy, s_ready, mac_start, mac_clr_acc, mac_a, mac_b,
           res_valid, res_data, res_count
  );

  modport slave (
    output cfg_len, cfg_go, s_valid, s_a, s_b, mac_ready, mac_acc, res_ready,
    input  busy, s_ready, mac_start, mac_clr_acc, mac_a, mac_b,
           res_valid, res_data, res_count
  );
endinterface

// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: buffers (A,B) operand pairs in a small FIFO and runs one
// dot product of cfg_len pairs on an external MAC unit. It clears the
// accumulator, issues one multiply at a time, waits for each done pulse, then
// presents the final accumulator value on a valid/ready result port.
// Optional build macro MAC_SEQ_STALL_CNT_EN adds a saturating stall_cnt output
// that counts the ISSUE cycles spent waiting on an empty FIFO.
module mac_dot_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int LEN_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  mac_dot_sequencer_if.master bus
`ifdef MAC_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_SETTLE = 3'd4,
    ST_RESULT = 3'd5
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [2*DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [CNT_W-1:0]        fifo_cnt_r;
  logic [CNT_W-1:0]        fifo_cnt_nxt_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    empty_s;
  logic [LEN_WIDTH-1:0]    len_r;
  logic [LEN_WIDTH-1:0]    cnt_r;
  logic                    busy_r;
  logic                    s_ready_r;
  logic                    mac_start_r;
  logic                    mac_clr_acc_r;
  logic [DATA_WIDTH-1:0]   mac_a_r;
  logic [DATA_WIDTH-1:0]   mac_b_r;
  logic                    res_valid_r;
  logic [ACC_WIDTH-1:0]    res_data_r;
  logic [LEN_WIDTH-1:0]    res_count_r;

  assign bus.busy        = busy_r;
  assign bus.s_ready     = s_ready_r;
  assign bus.mac_start   = mac_start_r;
  assign bus.mac_clr_acc = mac_clr_acc_r;
  assign bus.mac_a       = mac_a_r;
  assign bus.mac_b       = mac_b_r;
  assign bus.res_valid   = res_valid_r;
  assign bus.res_data    = res_data_r;
  assign bus.res_count   = res_count_r;

  // FIFO handshake decode and next occupancy (push+pop leaves it unchanged)
  always_comb begin
    push_s         = bus.s_valid && s_ready_r;
    empty_s        = (fifo_cnt_r == CNT_W'(0));
    pop_s          = (state_r == ST_ISSUE) && !empty_s;
    fifo_cnt_nxt_s = fifo_cnt_r;
    if (push_s && !pop_s) begin
      fifo_cnt_nxt_s = fifo_cnt_r + CNT_W'(1);
    end else if (pop_s && !push_s) begin
      fifo_cnt_nxt_s = fifo_cnt_r - CNT_W'(1);
    end else begin
      fifo_cnt_nxt_s = fifo_cnt_r;
    end
  end

  // Sequencer next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.cfg_go) state_nxt_s = ST_CLEAR;
        else            state_nxt_s = ST_IDLE;
      end
      ST_CLEAR: begin
        if (len_r == LEN_WIDTH'(0)) state_nxt_s = ST_SETTLE;
        else                        state_nxt_s = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!empty_s) state_nxt_s = ST_WAIT;
        else          state_nxt_s = ST_ISSUE;
      end
      ST_WAIT: begin
        if (bus.mac_ready) begin
          if ((cnt_r + LEN_ONE) == len_r) state_nxt_s = ST_SETTLE;
          else                            state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_SETTLE: state_nxt_s = ST_RESULT;
      ST_RESULT: begin
        if (bus.res_ready) state_nxt_s = ST_IDLE;
        else               state_nxt_s = ST_RESULT;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Operand FIFO storage, pointers and registered not-full flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fifo_cnt_r <= '0;
      s_ready_r  <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {bus.s_a, bus.s_b};
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      fifo_cnt_r <= fifo_cnt_nxt_s;
      s_ready_r  <= (fifo_cnt_nxt_s != CNT_W'(FIFO_DEPTH));
    end
  end

  // Length/progress counters, MAC control pulses, held operands and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_r         <= '0;
      cnt_r         <= '0;
      busy_r        <= 1'b0;
      mac_start_r   <= 1'b0;
      mac_clr_acc_r <= 1'b0;
      mac_a_r       <= '0;
      mac_b_r       <= '0;
      res_valid_r   <= 1'b0;
      res_data_r    <= '0;
      res_count_r   <= '0;
    end else begin
      if ((state_r == ST_IDLE) && bus.cfg_go) begin
        len_r <= bus.cfg_len;
        cnt_r <= '0;
      end else if ((state_r == ST_WAIT) && bus.mac_ready) begin
        cnt_r <= cnt_r + LEN_ONE;
      end
      if (pop_s) begin
        mac_a_r <= mem_r[rd_ptr_r][2*DATA_WIDTH-1:DATA_WIDTH];
        mac_b_r <= mem_r[rd_ptr_r][DATA_WIDTH-1:0];
      end
      if (state_r == ST_SETTLE) begin
        res_data_r  <= bus.mac_acc;
        res_count_r <= cnt_r;
      end
      // Outputs are decoded from the next state so they align with their state.
      busy_r        <= (state_nxt_s != ST_IDLE);
      mac_start_r   <= pop_s;
      mac_clr_acc_r <= (state_nxt_s == ST_CLEAR);
      res_valid_r   <= (state_nxt_s == ST_RESULT);
    end
  end

`ifdef MAC_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt_r;
  assign stall_cnt = stall_cnt_r;

  // Saturating count of ISSUE cycles starved by an empty FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 16'h0000;
    end else if (state_r == ST_CLEAR) begin
      stall_cnt_r <= 16'h0000;
    end else if ((state_r == ST_ISSUE) && empty_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Self-checking bench for mac_dot_sequencer: behavioural MAC unit, table of
// directed dot products, corner-case sequences and randomized dot products
// checked against a queue-based reference model.
module tb_mac_dot_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_dot_sequencer_if bus ();

`ifdef MAC_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  mac_dot_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MAC_SEQ_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- behavioural MAC unit ----------------
  int                 tmul = 1;
  int                 mul_left;
  logic signed [15:0] op_a, op_b;
  logic signed [39:0] prod;
  assign prod = 40'(op_a) * 40'(op_b);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mac_ready <= 1'b0;
      bus.mac_acc   <= '0;
      mul_left      <= 0;
      op_a          <= '0;
      op_b          <= '0;
    end else begin
      bus.mac_ready <= 1'b0;
      if (bus.mac_ready)   bus.mac_acc <= bus.mac_acc + prod;
      if (bus.mac_clr_acc) bus.mac_acc <= '0;
      if (bus.mac_start) begin
        op_a     <= $signed(bus.mac_a);
        op_b     <= $signed(bus.mac_b);
        mul_left <= tmul;
      end else if (mul_left > 0) begin
        mul_left <= mul_left - 1;
        if (mul_left == 1) bus.mac_ready <= 1'b1;
      end
    end
  end

  // ---------------- protocol monitor ----------------
  logic mon_clear = 1'b0;
  int   mon_starts = 0, mon_clrs = 0, mon_both = 0, mon_unstable = 0;

  always @(posedge clk) begin
    if (mon_clear) begin
      mon_starts   <= 0;
      mon_clrs     <= 0;
      mon_both     <= 0;
      mon_unstable <= 0;
    end else begin
      if (bus.mac_start)                     mon_starts <= mon_starts + 1;
      if (bus.mac_clr_acc)                   mon_clrs   <= mon_clrs + 1;
      if (bus.mac_start && bus.mac_clr_acc)  mon_both   <= mon_both + 1;
      if (bus.mac_ready && ((bus.mac_a != op_a) || (bus.mac_b != op_b)))
        mon_unstable <= mon_unstable + 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_pair(input logic [15:0] a, input logic [15:0] b, output int waited);
    waited = 0;
    bus.s_valid = 1'b1;
    bus.s_a     = a;
    bus.s_b     = b;
    while (!bus.s_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 300) check("push_timeout", 64'd1, 64'd0);
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  // Full dot product: go, wait for result, hold result 'hold' cycles, accept.
  task automatic run_dot(input string name, input int len, input int tm,
                         input logic signed [39:0] exp_d, input int hold);
    int guard;
    logic [39:0] held;
    tmul = tm;
    mon_clear = 1'b1;
    @(negedge clk);
    mon_clear = 1'b0;
    bus.cfg_len = 8'(len);
    bus.cfg_go  = 1'b1;
    @(negedge clk);
    bus.cfg_go  = 1'b0;
    guard = 0;
    while (!bus.res_valid && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_res_valid"}, longint'(bus.res_valid), 64'd1);
    check({name, "_res_data"}, longint'($signed(bus.res_data)), longint'(exp_d));
    check({name, "_res_count"}, longint'(bus.res_count), longint'(len));
    held = bus.res_data;
    for (int i = 0; i < hold; i++) begin
      bus.cfg_go = (i == 3);
      @(negedge clk);
      check({name, "_hold_valid"}, longint'(bus.res_valid), 64'd1);
      check({name, "_hold_data"}, longint'(bus.res_data), longint'(held));
    end
    bus.cfg_go    = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check({name, "_valid_drop"}, longint'(bus.res_valid), 64'd0);
    check({name, "_idle"}, longint'(bus.busy), 64'd0);
    check({name, "_starts"}, longint'(mon_starts), longint'(len));
    check({name, "_clrs"}, longint'(mon_clrs), 64'd1);
    check({name, "_start_and_clr"}, longint'(mon_both), 64'd0);
    check({name, "_operand_stable"}, longint'(mon_unstable), 64'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int                 len;
    int                 tm;
    int                 hold;
    logic [3:0][15:0]   a;
    logic [3:0][15:0]   b;
    logic signed [39:0] exp_d;
  } vec_t;

  vec_t vecs [5];

  // ---------------- random reference model ----------------
  typedef struct {
    logic signed [15:0] a;
    logic signed [15:0] b;
  } pair_t;

  pair_t model_q[$];
  pair_t pend[$];

  task automatic pusher();
    int w;
    while (pend.size() > 0) begin
      pair_t p;
      p = pend.pop_front();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      push_pair(p.a, p.b, w);
    end
  endtask

  initial begin
    int w;
    int w5;
    longint s;
    logic signed [39:0] e;
    bus.cfg_len = '0; bus.cfg_go = 1'b0; bus.s_valid = 1'b0;
    bus.s_a = '0; bus.s_b = '0; bus.res_ready = 1'b0;

    vecs[0] = '{len: 3, tm: 1, hold: 10,
                a: {16'sd0, 16'sd7, -16'sd4, 16'sd2},
                b: {16'sd0, -16'sd1, 16'sd5, 16'sd3}, exp_d: -40'sd21};
    vecs[1] = '{len: 1, tm: 3, hold: 0,
                a: {16'sd0, 16'sd0, 16'sd0, 16'h8000},
                b: {16'sd0, 16'sd0, 16'sd0, 16'h8000}, exp_d: 40'sd1073741824};
    vecs[2] = '{len: 4, tm: 2, hold: 0,
                a: {16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767},
                b: {16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767}, exp_d: 40'sd4294705156};
    vecs[3] = '{len: 2, tm: 1, hold: 0,
                a: {16'sd0, 16'sd0, -16'sd7, 16'sd100},
                b: {16'sd0, 16'sd0, -16'sd9, -16'sd3}, exp_d: -40'sd237};
    vecs[4] = '{len: 0, tm: 1, hold: 2,
                a: {16'sd0, 16'sd0, 16'sd0, 16'sd0},
                b: {16'sd0, 16'sd0, 16'sd0, 16'sd0}, exp_d: 40'sd0};

    // Reset state
    #2;
    check("rst_busy", longint'(bus.busy), 64'd0);
    check("rst_res_valid", longint'(bus.res_valid), 64'd0);
    check("rst_mac_start", longint'(bus.mac_start), 64'd0);
    check("rst_mac_clr", longint'(bus.mac_clr_acc), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_ready", longint'(bus.s_ready), 64'd1);

    // Reset in the middle of a multiply aborts everything
    push_pair(16'sd5, 16'sd6, w);
    tmul = 20;
    bus.cfg_len = 8'd1; bus.cfg_go = 1'b1;
    @(negedge clk);
    bus.cfg_go = 1'b0;
    w = 0;
    while (!bus.mac_start && w < 50) begin @(negedge clk); w++; end
    check("abort_saw_start", longint'(bus.mac_start), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", longint'(bus.busy), 64'd0);
    check("abort_mac_a", longint'(bus.mac_a), 64'd0);
    check("abort_mac_b", longint'(bus.mac_b), 64'd0);
    check("abort_mac_start", longint'(bus.mac_start), 64'd0);
    check("abort_res_data", longint'(bus.res_data), 64'd0);
    check("abort_res_count", longint'(bus.res_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_s_ready", longint'(bus.s_ready), 64'd1);

    // Directed table (vector 0 also holds the result with res_ready low)
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < vecs[v].len; i++) push_pair(vecs[v].a[i], vecs[v].b[i], w);
      run_dot($sformatf("vec%0d", v), vecs[v].len, vecs[v].tm, vecs[v].exp_d, vecs[v].hold);
    end

    // FIFO full: 4 pushes fill it, 5th waits until the first pop
    push_pair(16'sd1, 16'sd2, w);
    push_pair(16'sd3, 16'sd4, w);
    push_pair(-16'sd5, 16'sd6, w);
    push_pair(16'sd7, 16'sd8, w);
    check("full_s_ready", longint'(bus.s_ready), 64'd0);
    fork
      push_pair(16'sd9, -16'sd10, w5);
      run_dot("full_first", 1, 2, 40'sd2, 0);
    join
    check("full_fifth_waited", longint'(w5 > 0), 64'd1);
    run_dot("full_rest", 4, 1, 40'sd12 - 40'sd30 + 40'sd56 - 40'sd90, 0);

    // Randomized dot products against the queue model
    for (int it = 0; it < 15; it++) begin
      int len, extra;
      len   = $urandom_range(1, 6);
      extra = (model_q.size() < 2) ? $urandom_range(0, 1) : 0;
      for (int i = 0; i < len + extra; i++) begin
        pair_t p;
        p.a = 16'($urandom);
        p.b = 16'($urandom);
        model_q.push_back(p);
        pend.push_back(p);
      end
      s = 0;
      for (int i = 0; i < len; i++) begin
        pair_t p;
        p = model_q.pop_front();
        s += longint'(p.a) * longint'(p.b);
      end
      e = s[39:0];
      fork
        pusher();
        run_dot($sformatf("rand%0d", it), len, $urandom_range(1, 4), e, 0);
      join
    end
    // Drain leftovers so the FIFO is empty again
    if (model_q.size() > 0) begin
      s = 0;
      w = model_q.size();
      while (model_q.size() > 0) begin
        pair_t p;
        p = model_q.pop_front();
        s += longint'(p.a) * longint'(p.b);
      end
      e = s[39:0];
      run_dot("drain", w, 1, e, 0);
    end

`ifdef MAC_SEQ_STALL_CNT_EN
    // Second pair arrives 7 cycles into ISSUE with an empty FIFO
    push_pair(16'sd3, 16'sd4, w);
    tmul = 1;
    bus.cfg_len = 8'd2; bus.cfg_go = 1'b1;
    @(negedge clk);
    bus.cfg_go = 1'b0;
    w = 0;
    while (!bus.mac_ready && w < 50) begin @(negedge clk); w++; end
    repeat (7) @(negedge clk);
    push_pair(16'sd5, 16'sd6, w);
    w = 0;
    while (!bus.res_valid && w < 100) begin @(negedge clk); w++; end
    check("stall_res_data", longint'($signed(bus.res_data)), 64'd42);
    check("stall_cnt", longint'(stall_cnt), 64'd7);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
